// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. It runs from a 16x oversample enable and holds
//            each byte in a single ready/clear output register. An optional
//            parity bit is enabled with the macro UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int SAMPLE_MID = 7,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxclk_en_i,
    input  logic                 rx_i,
    input  logic                 rdy_clr_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rdy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] c_SAMPLE_MID = 4'(SAMPLE_MID);
    localparam logic [3:0] c_SAMPLE_END = 4'hF;
    localparam logic [2:0] c_LAST_BIT   = 3'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || SAMPLE_MID < 0 || SAMPLE_MID > 15 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("uart_rx: illegal parameter value");
        end
    endgenerate

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [3:0]           r_sample_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_done;
    logic                 w_accept;

    assign w_done   = rxclk_en_i && (r_state == ST_STOP) && (r_sample_cnt == c_SAMPLE_END);
    assign w_accept = !r_rdy || rdy_clr_i;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_parity_err;

    assign w_parity_err = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (rxclk_en_i && r_state == ST_PARITY && r_sample_cnt == c_SAMPLE_END)
                r_par_bit <= r_rx_s;
            if (w_done) begin
                if (w_accept)
                    r_parity_err <= w_parity_err;
            end else if (rdy_clr_i) begin
                r_parity_err <= 1'b0;
            end
        end
    end

    assign parity_err_o = r_parity_err;
`endif

    // Synchronizer idles high so that reset release never looks like a start edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_busy       <= 1'b0;
        end else if (rxclk_en_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state      <= ST_START;
                        r_sample_cnt <= 4'd0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_sample_cnt == c_SAMPLE_MID) begin
                        r_sample_cnt <= 4'd0;
                        r_bit_cnt    <= 3'd0;
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    r_sample_cnt <= r_sample_cnt + 4'd1;
                    if (r_sample_cnt == c_SAMPLE_END) begin
                        // Line order is LSB first, so bits enter at the top.
                        r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
                ST_PARITY: begin
                    r_sample_cnt <= r_sample_cnt + 4'd1;
                    if (r_sample_cnt == c_SAMPLE_END)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    r_sample_cnt <= r_sample_cnt + 4'd1;
                    if (r_sample_cnt == c_SAMPLE_END) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry holding register; a clear on the completion clock frees the slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data      <= '0;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_done) begin
            if (w_accept) begin
                r_data      <= r_shift;
                r_rdy       <= 1'b1;
                r_frame_err <= !r_rx_s;
                r_overrun   <= 1'b0;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (rdy_clr_i) begin
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign data_o      = r_data;
    assign rdy_o       = r_rdy;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx (16x enable every 4 clks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rxclk_en;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int phase    = 0;

    uart_rx #(
        .DATA_BITS (8),
        .SAMPLE_MID(7),
        .PARITY_ODD(0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rxclk_en_i  (rxclk_en),
        .rx_i        (rx),
        .rdy_clr_i   (rdy_clr),
        .data_o      (data),
        .rdy_o       (rdy),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .busy_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rxclk_en = 1'b0;
        forever begin
            @(negedge clk);
            phase    = (phase + 1) % 4;
            rxclk_en = (phase == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Start the frame so that the first enable tick after synchronization sees it.
    task automatic align();
        @(negedge clk);
        #1;
        while (phase != 2) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input logic clr_at_done);
        align();
        rx = 1'b0;
        wait_clks(64);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(64);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clks(64);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        if (clr_at_done) begin
            wait_clks(34);
            rdy_clr = 1'b1;
            wait_clks(1);
            rdy_clr = 1'b0;
            wait_clks(29);
        end else begin
            wait_clks(64);
        end
        rx = 1'b1;
        wait_clks(8);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        wait_clks(1);
        rdy_clr = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        rdy_clr = 1'b0;
        wait_clks(5);
        check("rst_data", data, 0);
        check("rst_rdy", rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {frame_err, overrun}, 0);
        rst = 1'b0;
        wait_clks(10);

        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check("f55_data", data, 8'h55);
        check("f55_rdy", rdy, 1);
        check("f55_flags", {frame_err, overrun}, 0);
        check("f55_busy_after", busy, 0);
        pulse_clr();
        check("f55_clr_rdy", rdy, 0);

        align();
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(64);
        check("glitch_busy", busy, 0);
        check("glitch_rdy", rdy, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("f3c_data", data, 8'h3C);
        check("f3c_rdy", rdy, 1);
        pulse_clr();

        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        check("fa3_data", data, 8'hA3);
        check("fa3_rdy", rdy, 1);
        check("fa3_frame_err", frame_err, 1);
        wait_clks(30);
        pulse_clr();
        check("fa3_clr_rdy", rdy, 0);
        check("fa3_clr_ferr", frame_err, 0);
        check("fa3_hold_data", data, 8'hA3);

        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0);
        check("ovr_data", data, 8'h12);
        check("ovr_flag", overrun, 1);
        check("ovr_rdy", rdy, 1);
        pulse_clr();
        check("ovr_clr_rdy", rdy, 0);
        check("ovr_clr_flag", overrun, 0);
        pulse_clr();
        check("clr_idle_noeffect", {rdy, overrun, frame_err}, 0);

        send_frame(8'h34, 1'b1, 1'b0, 1'b0);
        send_frame(8'h56, 1'b1, 1'b0, 1'b1);
        check("same_clk_data", data, 8'h56);
        check("same_clk_rdy", rdy, 1);
        check("same_clk_ovr", overrun, 0);

        align();
        rx = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            wait_clks(64);
        end
        rst = 1'b1;
        #1;
        check("arst_data", data, 0);
        check("arst_rdy", rdy, 0);
        check("arst_busy", busy, 0);
        wait_clks(2);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clks(20);
        check("arst_no_partial", rdy, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check("fc3_data", data, 8'hC3);
        check("fc3_rdy", rdy, 1);
        pulse_clr();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("par_ok_data", data, 8'h07);
        check("par_ok_err", parity_err, 0);
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check("par_bad_err", parity_err, 1);
        check("par_bad_data", data, 8'h07);
        pulse_clr();
        check("par_clr_err", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the peripheral UART part.
- Consumes the 16x-oversampling enable produced by the baud rate generator.
- Detects and validates start bits, samples each bit at mid-period, and deframes the bits into a byte.
- Holds the byte in a single-entry output register with a ready/clear handshake toward the UART register/bus interface; reports framing and overrun errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first (legal 5..8).
- SAMPLE_MID, 7, oversample tick index (0..15) at which the start bit is re-checked.
- PARITY_ODD, 0, parity sense when the parity option is compiled in: 0 = even, 1 = odd.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous reset, active-high
- rxclk_en_i  input  1  one-clk pulse at 16x baud rate
- rx_i  input  1  serial line, asynchronous, idle high
- rdy_clr_i  input  1  one-clk pulse: consumer has taken data_o
- data_o  output  DATA_BITS  received byte, stable while rdy_o=1
- rdy_o  output  1  received byte valid
- frame_err_o  output  1  stop bit of the held byte sampled low
- overrun_o  output  1  a frame completed while rdy_o=1; that frame was dropped
- busy_o  output  1  frame reception in progress

Behaviour:
- Reset (rst_i=1, asynchronous):
  - data_o=0, rdy_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Synchronizer flops=1, state=IDLE, sample_cnt=0, bit_cnt=0.
  - Reset asserted mid-frame aborts the frame; no partial data is delivered.
- Input sync: rx_i passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- Counters:
  - sample_cnt is 4-bit and advances only on clocks where rxclk_en_i=1; it wraps 15->0.
  - bit_cnt is 3-bit and counts data bits received.
- State machine (transitions evaluated only on rxclk_en_i=1):
  - IDLE: if rx_s=0 -> START with sample_cnt=0. busy_o=0.
  - START: when sample_cnt==SAMPLE_MID, check rx_s.
    - rx_s=1: glitch, return to IDLE.
    - rx_s=0: go to DATA with sample_cnt=0, bit_cnt=0.
    - Otherwise increment sample_cnt.
  - DATA: when sample_cnt==15 (mid-bit), shift rx_s into the MSB of the shift register (LSB-first line order) and increment bit_cnt. After the DATA_BITS-th bit -> STOP (or PARITY, see option).
  - STOP: when sample_cnt==15, sample the stop bit, update outputs (below), then -> IDLE. Returning at mid-stop-bit allows back-to-back frames.
  - busy_o=1 in every state except IDLE.
- Completion, registered on the clock of the stop-bit sample tick:
  - If rdy_o=0, or rdy_clr_i=1 on the same clock:
    - data_o <= shifted byte.
    - rdy_o <= 1.
    - frame_err_o <= (stop bit == 0).
  - If rdy_o=1 and rdy_clr_i=0:
    - data_o, rdy_o and frame_err_o are unchanged.
    - overrun_o <= 1; the new frame is discarded.
- rdy_clr_i=1 with no completion on that clock: rdy_o, frame_err_o and overrun_o clear next clock. data_o holds its value.
- rdy_clr_i while rdy_o=0: no effect.
- Latency: rdy_o rises one clk after the rxclk_en_i tick at the stop-bit mid-sample. This is about 9.5 bit periods after the falling start edge, plus 2-3 clks of synchronizer delay.
- A frame is accepted with start, data and stop samples taken from rx_s even if the line toggles between samples (no majority vote).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters PARITY.
  - At sample_cnt==15 it samples the parity bit, then goes to STOP.
  - Adds output parity_err_o (1 bit, reset 0).
  - parity_err_o is set when XOR(data bits, parity bit) != PARITY_ODD. It updates, holds and clears exactly like frame_err_o.
- Undefined: no PARITY state and no parity_err_o port; the frame is 8N1.

Test Plan:
- Bench setup: rxclk_en_i pulses 1 clk in every 4, so one bit period = 64 clks.
- Frame 0x55 with stop=1 -> rdy_o=1, data_o=0x55, frame_err_o=0, overrun_o=0. busy_o=1 during the frame and 0 after the stop sample.
- Start glitch: rx_i low for 3 rxclk_en ticks, then high -> FSM back to IDLE, busy_o=0, rdy_o stays 0. A following frame 0x3C is received correctly.
- Frame 0xA3 with stop bit driven 0 -> rdy_o=1, data_o=0xA3, frame_err_o=1. A rdy_clr_i pulse -> rdy_o=0, frame_err_o=0, data_o still 0xA3.
- Overrun:
  - Frames 0x12 then 0x34 with no rdy_clr_i -> data_o=0x12, overrun_o=1.
  - rdy_clr_i -> rdy_o=0, overrun_o=0.
  - rdy_clr_i on the exact completion clock of 0x56 -> data_o=0x56, rdy_o=1, overrun_o=0.
- rst_i asserted for 2 clks after 4 data bits of 0xF0 -> all outputs 0 immediately, busy_o=0. A following frame 0xC3 gives data_o=0xC3, rdy_o=1.
- With UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err_o=0; 0x07 with parity bit 0 -> parity_err_o=1, data_o=0x07.
